instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_pkg.sv | 13 +
 rtl/up_down_cnt.sv | 37 +++
 rtl/instr_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package instr_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/up_down_cnt.sv
// Saturating up/down counter used to track instruction FIFO credits.
module up_down_cnt #(
    parameter int MAX  = 4,
    parameter int INIT = MAX,
    parameter int W    = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Simultaneous inc and dec cancel; the range is held to 0..MAX.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != W'(MAX))) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= W'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Issues line-read requests for a program, bounded by downstream FIFO credit.
//   state    | meaning
//   IDLE     | waiting for start
//   FETCH    | issuing requests while credit allows
//   DRAIN    | waiting for outstanding responses
//   DONE     | one-cycle completion pulse
module instr_fetch_ctrl
    import instr_pkg::*;
#(
    parameter int WORD_LEN         = 32,
    parameter int INSTR_FIFO_WIDTH = 16,
    parameter int ADDR_W           = 16,
    parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [ADDR_W-1:0]                    base_addr,
    input  logic [ADDR_W-1:0]                    n_lines,
    input  logic                                 abort,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 aborted,
    output logic                                 mem_req_vld,
    input  logic                                 mem_req_rdy,
    output logic [ADDR_W-1:0]                    mem_req_addr,
    input  logic                                 mem_rsp_vld,
    input  logic [INSTR_FIFO_WIDTH*WORD_LEN-1:0] mem_rsp_data,
    output logic                                 fifo_push,
    output logic [INSTR_FIFO_WIDTH*WORD_LEN-1:0] fifo_push_data,
    input  logic                                 fifo_pop
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] n_lines_q, n_lines_d;
    logic [ADDR_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [CNT_W-1:0]  credit;
    logic              req_acc;

    assign mem_req_vld    = (state_q == ST_FETCH) && (credit != '0) && !abort;
    assign mem_req_addr   = base_q + req_cnt_q;
    assign req_acc        = mem_req_vld && mem_req_rdy;
    assign fifo_push      = mem_rsp_vld;
    assign fifo_push_data = mem_rsp_data;

    up_down_cnt #(
        .MAX  (FIFO_DEPTH),
        .INIT (FIFO_DEPTH),
        .W    (CNT_W)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .inc   (fifo_pop),
        .dec   (req_acc),
        .count (credit)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        n_lines_d = n_lines_q;
        req_cnt_d = req_cnt_q;
        aborted_d = aborted_q;

        unique case ({req_acc, mem_rsp_vld})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase

        if (req_acc) begin
            req_cnt_d = req_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    aborted_d = 1'b0;
                    if (n_lines != '0) begin
                        state_d   = ST_FETCH;
                        base_d    = base_addr;
                        n_lines_d = n_lines;
                        req_cnt_d = '0;
                        outst_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d   = ST_DRAIN;
                    aborted_d = 1'b1;
                end else if (req_acc && (req_cnt_d == n_lines_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            // Looking at the post-update count lets DONE follow the last response directly.
            ST_DRAIN: begin
                if (outst_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            n_lines_q <= '0;
            req_cnt_q <= '0;
            outst_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            n_lines_q <= n_lines_d;
            req_cnt_q <= req_cnt_d;
            outst_q   <= outst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

    // Protocol checks on the memory and FIFO sides.
    a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
        !(mem_rsp_vld && (outst_q == '0)));
    a_pop_at_full_credit: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_pop && (credit == CNT_W'(FIFO_DEPTH))));
    a_outst_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(outst_q > CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl with a simple memory/FIFO model.
module tb_instr_fetch_ctrl;

    localparam int LINE_W = 16 * 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [15:0]       base_addr;
    logic [15:0]       n_lines;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              mem_req_vld;
    logic              mem_req_rdy;
    logic [15:0]       mem_req_addr;
    logic              mem_rsp_vld;
    logic [LINE_W-1:0] mem_rsp_data;
    logic              fifo_push;
    logic [LINE_W-1:0] fifo_push_data;
    logic              fifo_pop;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .n_lines        (n_lines),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .mem_req_vld    (mem_req_vld),
        .mem_req_rdy    (mem_req_rdy),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_vld    (mem_rsp_vld),
        .mem_rsp_data   (mem_rsp_data),
        .fifo_push      (fifo_push),
        .fifo_push_data (fifo_push_data),
        .fifo_pop       (fifo_pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc;

    logic [15:0]       pend[$];
    logic [15:0]       acc_addr[$];
    int                acc_cyc[$];
    int                n_push;
    int                push_cyc;
    int                done_cnt;
    int                done_cyc;
    logic              ab_at_done;
    logic [LINE_W-1:0] first_data;
    int                fifo_cnt = 0;
    logic              rsp_en;
    logic              pop_en;
    logic              snap_vld, snap_busy, snap_done, snap_ab;

    function automatic logic [LINE_W-1:0] line_of(input logic [15:0] a);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = {a, 16'(i)};
        return l;
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        acc_addr.delete();
        acc_cyc.delete();
        n_push     = 0;
        push_cyc   = -1;
        done_cnt   = 0;
        done_cyc   = -1;
        ab_at_done = 1'b0;
        first_data = '0;
    endtask

    // Observe at the falling edge, then drive the memory/FIFO model just after the rising edge.
    task automatic tick();
        #4;
        snap_vld  = mem_req_vld;
        snap_busy = busy;
        snap_done = done;
        snap_ab   = aborted;
        if (mem_req_vld && mem_req_rdy) begin
            acc_addr.push_back(mem_req_addr);
            acc_cyc.push_back(cyc);
            pend.push_back(mem_req_addr);
        end
        if (fifo_push) begin
            n_push++;
            push_cyc = cyc;
            if (n_push == 1) first_data = fifo_push_data;
            fifo_cnt++;
        end
        if (fifo_pop) fifo_cnt--;
        if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
                done_cyc   = cyc;
                ab_at_done = aborted;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_rsp_vld = 1'b0;
        if (rsp_en && (pend.size() > 0)) begin
            mem_rsp_vld  = 1'b1;
            mem_rsp_data = line_of(pend.pop_front());
        end
        if (pop_en) fifo_pop = (fifo_cnt > 0);
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] n);
        base_addr = b;
        n_lines   = n;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic run_until_done();
        for (int i = 0; i < 40 && done_cnt == 0; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; n_lines = '0; abort = 1'b0;
        mem_req_rdy = 1'b0; mem_rsp_vld = 1'b0; mem_rsp_data = '0; fifo_pop = 1'b0;
        rsp_en = 1'b0; pop_en = 1'b0;
        clr_log();
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_busy", snap_busy, 0);
        chk("rst_done", snap_done, 0);
        chk("rst_aborted", snap_ab, 0);
        chk("rst_req_vld", snap_vld, 0);
        rst = 1'b1;
        mem_req_rdy = 1'b1;
        tick();

        // basic run: base 0x10, 3 lines, immediate pops
        rsp_en = 1'b1; pop_en = 1'b1;
        clr_log();
        do_start(16'h0010, 16'd3);
        run_until_done();
        chk("t1_acc_cnt", acc_addr.size(), 3);
        chk("t1_addr0", acc_addr[0], 16'h0010);
        chk("t1_addr1", acc_addr[1], 16'h0011);
        chk("t1_addr2", acc_addr[2], 16'h0012);
        chk("t1_first_latency", acc_cyc[0] - start_cyc, 1);
        chk("t1_consecutive", acc_cyc[2] - acc_cyc[0], 2);
        chk("t1_push_cnt", n_push, 3);
        chk("t1_push_data", first_data, line_of(16'h0010));
        chk("t1_done_after_rsp", done_cyc - push_cyc, 1);
        chk("t1_aborted", ab_at_done, 0);
        tick();
        tick();
        chk("t1_done_once", done_cnt, 1);
        chk("t1_idle_busy", snap_busy, 0);

        // credit stall: 6 lines, no pops
        pop_en = 1'b0; fifo_pop = 1'b0;
        clr_log();
        do_start(16'h0100, 16'd6);
        repeat (6) tick();
        chk("t2_stall_acc", acc_addr.size(), 4);
        chk("t2_stall_vld", snap_vld, 0);
        chk("t2_stall_busy", snap_busy, 1);
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        repeat (4) tick();
        chk("t2_one_pop_acc", acc_addr.size(), 5);
        chk("t2_one_pop_vld", snap_vld, 0);
        fifo_pop = 1'b1;
        tick();
        fifo_pop = 1'b0;
        run_until_done();
        chk("t2_final_acc", acc_addr.size(), 6);
        chk("t2_addr5", acc_addr[5], 16'h0105);
        chk("t2_push_cnt", n_push, 6);
        chk("t2_done_seen", done_cnt, 1);
        pop_en = 1'b1;
        repeat (8) tick();

        // address wrap
        clr_log();
        do_start(16'hFFFE, 16'd3);
        run_until_done();
        chk("t3_acc_cnt", acc_addr.size(), 3);
        chk("t3_addr0", acc_addr[0], 16'hFFFE);
        chk("t3_addr1", acc_addr[1], 16'hFFFF);
        chk("t3_addr2", acc_addr[2], 16'h0000);
        repeat (3) tick();

        // abort after 2 accepts with both responses held back
        rsp_en = 1'b0;
        clr_log();
        do_start(16'h0200, 16'd8);
        tick();
        tick();
        abort = 1'b1;
        tick();
        chk("t4_abort_vld", snap_vld, 0);
        tick();
        abort = 1'b0;
        rsp_en = 1'b1;
        run_until_done();
        chk("t4_acc_cnt", acc_addr.size(), 2);
        chk("t4_push_cnt", n_push, 2);
        chk("t4_done_seen", done_cnt, 1);
        chk("t4_aborted_at_done", ab_at_done, 1);
        tick();
        tick();
        chk("t4_aborted_holds", snap_ab, 1);
        chk("t4_idle_done", snap_done, 0);

        // zero-line program
        clr_log();
        do_start(16'h0000, 16'd0);
        tick();
        chk("t5_done_next", done_cyc - start_cyc, 1);
        chk("t5_aborted_cleared", ab_at_done, 0);
        tick();
        tick();
        chk("t5_acc_cnt", acc_addr.size(), 0);
        chk("t5_done_once", done_cnt, 1);

        // start while busy is ignored
        clr_log();
        do_start(16'h0300, 16'd3);
        tick();
        base_addr = 16'h0400; n_lines = 16'd1; start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done();
        repeat (4) tick();
        chk("t6_acc_cnt", acc_addr.size(), 3);
        chk("t6_addr2", acc_addr[2], 16'h0302);
        chk("t6_done_once", done_cnt, 1);

        // reset mid-FETCH: run abandoned, credit restored
        rsp_en = 1'b0; pop_en = 1'b0; fifo_pop = 1'b0;
        clr_log();
        do_start(16'h0500, 16'd8);
        tick();
        tick();
        chk("t7_pre_rst_acc", acc_addr.size(), 2);
        clr_log();
        rst = 1'b0; mem_req_rdy = 1'b0;
        pend.delete();
        tick();
        tick();
        rst = 1'b1; mem_req_rdy = 1'b1;
        tick();
        chk("t7_idle_busy", snap_busy, 0);
        chk("t7_idle_vld", snap_vld, 0);
        chk("t7_no_done", done_cnt, 0);
        rsp_en = 1'b1;
        clr_log();
        do_start(16'h0600, 16'd6);
        repeat (7) tick();
        chk("t7_credit_acc", acc_addr.size(), 4);
        chk("t7_credit_vld", snap_vld, 0);
        pop_en = 1'b1;
        run_until_done();
        chk("t7_final_acc", acc_addr.size(), 6);
        chk("t7_done_seen", done_cnt, 1);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
